float_to_double: RTL and testbench
==================================

FLOAT_TO_DOUBLE -- requirements
Module: float_to_double

Interface
REQ-001 The block SHALL have the port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port `input_a`, input, 32 bits: IEEE-754 single-precision operand.
REQ-004 The block SHALL have the port `input_a_stb`, input, 1 bit: the producer holds `input_a` valid while this is high.
REQ-005 The block SHALL have the port `input_a_ack`, output, 1 bit, registered: the block is ready to accept an operand.
REQ-006 The block SHALL have the port `output_z`, output, 64 bits, registered: IEEE-754 double-precision result.
REQ-007 The block SHALL have the port `output_z_stb`, output, 1 bit, registered: `output_z` is valid.
REQ-008 The block SHALL have the port `output_z_ack`, input, 1 bit: the consumer accepts `output_z`.

Function
REQ-009 The state machine SHALL have four states: GET_A, UNPACK, NORMALISE, PUT_RESULT.
REQ-010 In GET_A, `input_a_ack` SHALL rise on the first edge in the state; the edge sampling `input_a_ack` and `input_a_stb` both high SHALL capture `input_a`, clear `input_a_ack` and go to UNPACK.
REQ-011 UNPACK SHALL take one edge: result sign = a[31]; it SHALL then go to PUT_RESULT, except for denormals (see REQ-014).
REQ-012 For a normal input (exponent 1..254), result exponent SHALL be a[30:23]+896 (11-bit) and result mantissa SHALL be {a[22:0], 29'b0}; the conversion is exact with no rounding.
REQ-013 For exponent 0 with a[22:0]==0, the result SHALL be a signed zero.
REQ-014 For exponent 0 with a[22:0]!=0, the block SHALL load a 24-bit mantissa {1'b0, a[22:0]} and an 11-bit exponent of 897, then go to NORMALISE.
REQ-015 Each NORMALISE edge with mantissa[23]==0 SHALL shift the mantissa left by 1 and decrement the exponent by 1; an edge with mantissa[23]==1 SHALL form the result {sign, exponent, mantissa[22:0], 29'b0} and go to PUT_RESULT; there are at most 23 shifts (minimum exponent 874).
REQ-016 For exponent 255 with mantissa zero, the result SHALL be a signed infinity (exponent 2047, mantissa 0).
REQ-017 For exponent 255 with mantissa nonzero, the result SHALL be a quiet NaN: sign kept, exponent 2047, mantissa {a[22:0], 29'b0} with bit 51 forced to 1.
REQ-018 In PUT_RESULT, the first edge SHALL load `output_z` and set `output_z_stb`; `output_z` SHALL stay stable while `output_z_stb` is high.
REQ-019 The edge sampling `output_z_stb` and `output_z_ack` both high SHALL clear `output_z_stb` and return to GET_A; `output_z` keeps its last value.
REQ-020 Latency from the accepting edge to `output_z_stb` visible high SHALL be 2 cycles for normal, zero, infinity and NaN inputs, and 3+k cycles for a denormal needing k shifts.
REQ-021 `input_a_ack` and `output_z_stb` SHALL never be high simultaneously; one operand is in flight at a time.
REQ-022 `output_z_ack` held high outside PUT_RESULT SHALL have no effect; `input_a_stb` outside GET_A SHALL be ignored.

Reset
REQ-023 While `reset_n` is low, the state SHALL be GET_A, `input_a_ack`=0, `output_z_stb`=0, `output_z`=64'h0, and all internal registers cleared.
REQ-024 Reset asserted in any state, including mid-NORMALISE or with `output_z_stb` pending, SHALL abort the operation with no output handshake.
REQ-025 `input_a_ack` SHALL rise on the first edge after `reset_n` deasserts.

Configuration
REQ-026 With the macro FLOAT_TO_DOUBLE_DENORM_EN defined, denormals SHALL be normalised per REQ-014/015.
REQ-027 Without FLOAT_TO_DOUBLE_DENORM_EN, the NORMALISE state and its registers SHALL be compiled out, and denormal inputs SHALL be flushed to a signed zero with 2-cycle latency.

Verification
REQ-028 The bench SHALL cover normals: 0x3F800000 -> 0x3FF0000000000000; 0xC0200000 -> 0xC004000000000000; each with `output_z_stb` 2 cycles after accept.
REQ-029 The bench SHALL cover specials: 0x80000000 -> 0x8000000000000000; 0x7F800000 -> 0x7FF0000000000000; 0x7F800001 and 0x7FC00001 -> 0x7FF8000020000000.
REQ-030 The bench SHALL cover denormals: 0x00000001 -> 0x36A0000000000000 after 26 cycles with the macro, and -> 0x0000000000000000 after 2 cycles without it; 0x00400000 -> 0x3800000000000000.
REQ-031 The bench SHALL cover backpressure: hold `output_z_ack` low 5 cycles after `output_z_stb` rises -> `output_z` stable, `input_a_ack` low, a single handshake on release.
REQ-032 The bench SHALL cover reset mid-NORMALISE: pulse `reset_n` low 3 cycles into 0x00000001 -> `output_z_stb` never rises and `output_z`=0; the next operand 0x3F800000 converts correctly.

Source files
------------

// File: rtl/float_to_double.sv
// IEEE-754 single to double converter with stb/ack handshakes on both sides.
// Define FLOAT_TO_DOUBLE_DENORM_EN to normalise denormals instead of flushing.
module float_to_double (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [63:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [1:0] {
      GET_A      = 2'd0,
      UNPACK     = 2'd1,
`ifdef FLOAT_TO_DOUBLE_DENORM_EN
      NORMALISE  = 2'd2,
`endif
      PUT_RESULT = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [63:0] res_q, res_d;
   logic [63:0] z_q, z_d;
   logic        ack_q, ack_d;
   logic        stb_q, stb_d;
`ifdef FLOAT_TO_DOUBLE_DENORM_EN
   logic [23:0] m_q, m_d;
   logic [10:0] e_q, e_d;
`endif

   logic        sgn;
   logic [7:0]  exp_w;
   logic [22:0] man_w;

   assign sgn   = a_q[31];
   assign exp_w = a_q[30:23];
   assign man_w = a_q[22:0];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      res_d   = res_q;
      z_d     = z_q;
      ack_d   = ack_q;
      stb_d   = stb_q;
`ifdef FLOAT_TO_DOUBLE_DENORM_EN
      m_d     = m_q;
      e_d     = e_q;
`endif
      unique case (state_q)
         GET_A: begin
            if (!ack_q) begin
               ack_d = 1'b1;
            end else if (input_a_stb) begin
               a_d     = input_a;
               ack_d   = 1'b0;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            state_d = PUT_RESULT;
            if (exp_w == 8'hFF) begin
               // NaN payload kept, quiet bit forced
               if (man_w == 23'd0)
                  res_d = {sgn, 11'h7FF, 52'd0};
               else
                  res_d = {sgn, 11'h7FF, 1'b1, man_w[21:0], 29'd0};
            end else if (exp_w == 8'h00) begin
               res_d = {sgn, 63'd0};
`ifdef FLOAT_TO_DOUBLE_DENORM_EN
               if (man_w != 23'd0) begin
                  m_d     = {1'b0, man_w};
                  e_d     = 11'd897;
                  state_d = NORMALISE;
               end
`endif
            end else begin
               res_d = {sgn, {3'b0, exp_w} + 11'd896, man_w, 29'd0};
            end
         end
`ifdef FLOAT_TO_DOUBLE_DENORM_EN
         NORMALISE: begin
            if (m_q[23]) begin
               res_d   = {sgn, e_q, m_q[22:0], 29'd0};
               state_d = PUT_RESULT;
            end else begin
               m_d = {m_q[22:0], 1'b0};
               e_d = e_q - 11'd1;
            end
         end
`endif
         PUT_RESULT: begin
            if (!stb_q) begin
               z_d   = res_q;
               stb_d = 1'b1;
            end else if (output_z_ack) begin
               stb_d   = 1'b0;
               state_d = GET_A;
            end
         end
         default: begin
            state_d = GET_A;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= GET_A;
         a_q     <= 32'd0;
         res_q   <= 64'd0;
         z_q     <= 64'd0;
         ack_q   <= 1'b0;
         stb_q   <= 1'b0;
`ifdef FLOAT_TO_DOUBLE_DENORM_EN
         m_q     <= 24'd0;
         e_q     <= 11'd0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         res_q   <= res_d;
         z_q     <= z_d;
         ack_q   <= ack_d;
         stb_q   <= stb_d;
`ifdef FLOAT_TO_DOUBLE_DENORM_EN
         m_q     <= m_d;
         e_q     <= e_d;
`endif
      end
   end

   assign input_a_ack  = ack_q;
   assign output_z     = z_q;
   assign output_z_stb = stb_q;

endmodule

// File: tb/tb_float_to_double.sv
// Directed-vector bench for float_to_double; expectations follow the
// FLOAT_TO_DOUBLE_DENORM_EN setting of the build.
module tb_float_to_double;

   logic        clock;
   logic        reset_n;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [63:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int n_chk;
   int n_err;

`ifdef FLOAT_TO_DOUBLE_DENORM_EN
   localparam logic [63:0] DEN1_Z   = 64'h36A0000000000000;
   localparam int          DEN1_LAT = 26;
   localparam logic [63:0] DEN2_Z   = 64'h3800000000000000;
   localparam int          DEN2_LAT = 4;
   localparam int          RST_AT   = 3;
`else
   localparam logic [63:0] DEN1_Z   = 64'h0000000000000000;
   localparam int          DEN1_LAT = 2;
   localparam logic [63:0] DEN2_Z   = 64'h0000000000000000;
   localparam int          DEN2_LAT = 2;
   localparam int          RST_AT   = 1;
`endif

   float_to_double dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Hand operand over; returns after the accepting edge (+1).
   task automatic send(input logic [31:0] a, input string tag);
      int n;
      n = 0;
      while (!input_a_ack && n < 50) begin
         tick();
         n++;
      end
      check({tag, " ack_wait"}, 64'(input_a_ack), 64'd1);
      input_a     = a;
      input_a_stb = 1'b1;
      tick();
      input_a_stb = 1'b0;
      input_a     = 32'hDEAD_BEEF;
      check({tag, " ack_drop"}, 64'(input_a_ack), 64'd0);
   endtask

   task automatic wait_stb(output int lat);
      lat = 0;
      while (!output_z_stb && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic convert(input logic [31:0] a,
                          input logic [63:0] exp_z,
                          input int exp_lat,
                          input string tag);
      int lat;
      send(a, tag);
      wait_stb(lat);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " z"}, output_z, exp_z);
      check({tag, " ack_lo"}, 64'(input_a_ack), 64'd0);
      tick();
      check({tag, " stb_clr"}, 64'(output_z_stb), 64'd0);
      check({tag, " z_hold"}, output_z, exp_z);
   endtask

   initial begin
      int lat;
      n_chk        = 0;
      n_err        = 0;
      reset_n      = 1'b0;
      input_a      = 32'd0;
      input_a_stb  = 1'b0;
      output_z_ack = 1'b1;
      #1;
      check("rst ack", 64'(input_a_ack), 64'd0);
      check("rst stb", 64'(output_z_stb), 64'd0);
      check("rst z", output_z, 64'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      check("ack after rst", 64'(input_a_ack), 64'd1);

      convert(32'h3F800000, 64'h3FF0000000000000, 2, "one");
      convert(32'hC0200000, 64'hC004000000000000, 2, "m2p5");
      convert(32'h80000000, 64'h8000000000000000, 2, "nzero");
      convert(32'h7F800000, 64'h7FF0000000000000, 2, "inf");
      convert(32'h7F800001, 64'h7FF8000020000000, 2, "snan");
      convert(32'h7FC00001, 64'h7FF8000020000000, 2, "qnan");
      convert(32'h00000001, DEN1_Z, DEN1_LAT, "den1");
      convert(32'h00400000, DEN2_Z, DEN2_LAT, "den2");
      convert(32'h7F7FFFFF, 64'h47EFFFFFE0000000, 2, "maxn");

      // Backpressure: consumer stalls for 5 cycles
      output_z_ack = 1'b0;
      send(32'h3F800000, "bp");
      wait_stb(lat);
      check("bp latency", 64'(lat), 64'd2);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp stb", 64'(output_z_stb), 64'd1);
         check("bp z", output_z, 64'h3FF0000000000000);
         check("bp ack", 64'(input_a_ack), 64'd0);
      end
      output_z_ack = 1'b1;
      tick();
      check("bp release", 64'(output_z_stb), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp single", 64'(output_z_stb), 64'd0);
      end

      // Reset while the denormal is in flight
      send(32'h00000001, "rst_mid");
      for (int i = 0; i < RST_AT - 1; i++) begin
         tick();
         check("rst_mid stb", 64'(output_z_stb), 64'd0);
      end
      reset_n = 1'b0;
      #1;
      check("rst_mid z", output_z, 64'd0);
      check("rst_mid stb0", 64'(output_z_stb), 64'd0);
      check("rst_mid ack", 64'(input_a_ack), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_mid nostb", 64'(output_z_stb), 64'd0);
      end
      convert(32'h3F800000, 64'h3FF0000000000000, 2, "after");

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
